mpu_fault_unit: RTL and testbench
=================================

// Module: mpu_fault_unit
// PURPOSE
//  Downstream of the memory MPU. Captures each MPU violation (interrupt rising edge) as a record of
//  offending PC, data address and access type, queued in a small FIFO. Raises a level IRQ to the
//  picorv32 core. The handler reads records and pops them through a word-addressed register port.
// PARAMETERS
//  FIFO_DEPTH  4   fault records held; power of two, >=2
//  ADDR_W      22  width of captured data address (matches mem bus)
//  DROP_W      8   width of saturating dropped-fault counter
// PORTS
//  clk         in   1       system clock
//  resetn      in   1       asynchronous, active-low reset
//  mpu_irq     in   1       MPU violation flag (level, held until MPU clears it)
//  pc_addr     in   32      PC of faulting instruction, valid while mpu_irq high
//  cpu_addr    in   ADDR_W  faulting data address, valid while mpu_irq high
//  cpu_wstrb   in   4       access strobe; nonzero = write fault, zero = read fault
//  reg_valid   in   1       register access request
//  reg_ready   out  1       one-cycle completion pulse
//  reg_addr    in   3       register word offset
//  reg_wdata   in   32      write data
//  reg_wstrb   in   4       nonzero = write, zero = read
//  reg_rdata   out  32      read data, valid while reg_ready is high
//  cpu_irq     out  1       IRQ to core (registered)
// BEHAVIOUR
//  - Reset: FIFO empty, ovf=0, drop_cnt=0, irq_en=1; reg_ready=0, reg_rdata=0, cpu_irq=0.
//  - Capture: register mpu_irq as irq_q. A push happens when mpu_irq && !irq_q.
//    Record = {write = |cpu_wstrb, addr = cpu_addr, pc = pc_addr}, sampled on that edge.
//    A level held for many cycles gives exactly one record.
//  - Push while full (and no pop that cycle): record dropped; ovf<=1; drop_cnt+1, saturating at all-ones.
//  - Push and pop in the same cycle: both take effect, count unchanged. This also holds when full.
//  - cpu_irq <= irq_en && (count_next != 0). Latency: edge sampled at clk N gives cpu_irq high after clk N.
//  - Register handshake: request sampled with reg_valid && !reg_ready.
//    reg_ready pulses high the next cycle for exactly one cycle. Back-to-back requests need valid re-sampled after ready.
//    Side effects commit on the same edge that raises reg_ready.
//  - Register map (word offsets):
//    0 STATUS  RO: [3:0]=count, [8]=ovf, [23:16]=drop_cnt. Write with wdata[8]=1 clears ovf and drop_cnt.
//    1 CTRL    RW: [0]=irq_en; other bits read 0.
//    2 HEAD_PC RO: pc of head record; 0 when empty.
//    3 HEAD_AD RO: [ADDR_W-1:0]=addr, [31]=write flag; 0 when empty.
//    4 POP     WO: any write pops the head; pop when empty is ignored. Reads return 0.
//    5-7       reads return 0; writes are ignored.
//  - Reads return state before any same-cycle push or pop.
//  - Clearing ovf at the same edge as an overflow drop: the set wins (ovf=1, drop_cnt=1).
//  - Reset asserted mid-transaction: everything returns to reset values immediately. Pending request is abandoned, no ready.
// STRUCTURE
//  - Package mpu_fault_pkg:
//    register offsets (REG_STATUS..REG_POP), STATUS bit positions, record width = 32+ADDR_W+1.
//  - One sub-module, fault_fifo: synchronous FIFO with push/pop/full/empty/count,
//    wrap-around pointers and show-ahead head.
//  - Top level holds edge detect, drop counter, CTRL and register decode.
// TESTING
//  1. Reset, then read STATUS/HEAD_PC/HEAD_AD -> all 0. cpu_irq=0. reg_ready exactly one cycle after valid.
//  2. mpu_irq held high 10 cycles, pc=0x100, addr=0x300, wstrb=4'hF
//     -> one record, count=1, HEAD_PC=0x100, HEAD_AD=0x8000_0300, cpu_irq high one cycle after edge.
//  3. Five fault edges with no pops (DEPTH=4)
//     -> count=4, ovf=1, drop_cnt=1. Write POP x4 -> cpu_irq low. Write STATUS[8]=1 -> ovf=0, drop_cnt=0.
//  4. FIFO full, POP write on the same edge as a new fault edge
//     -> count stays 4, no drop, new record is last. Reading 4 records gives FIFO order.
//  5. CTRL=0 with one fault -> cpu_irq=0, count=1. CTRL=1 -> cpu_irq=1 next cycle.
//  6. 300 overflow drops -> drop_cnt=255. Assert resetn low mid-read -> no reg_ready, all state cleared.

Source files
------------

// File: rtl/mpu_fault_pkg.sv
// mpu_fault_pkg: register map, STATUS layout and fault record width shared by the fault unit.
package mpu_fault_pkg;
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CTRL    = 3'd1;
    localparam logic [2:0] REG_HEAD_PC = 3'd2;
    localparam logic [2:0] REG_HEAD_AD = 3'd3;
    localparam logic [2:0] REG_POP     = 3'd4;
    localparam int STS_OVF      = 8;
    localparam int STS_DROP_LSB = 16;
    localparam int HEAD_WR_BIT  = 31;
    // Record layout, MSB first: {write, addr, pc}
    function automatic int rec_w(input int addr_w);
        return 32 + addr_w + 1;
    endfunction
endpackage

// File: rtl/mpu_fault_unit_if.sv
// mpu_fault_unit_if: word-addressed register port used by the IRQ handler.
interface mpu_fault_unit_if;
    logic        valid;
    logic        ready;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    modport master(output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave(input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mpu_fault_unit_fifo.sv
// fault_fifo: show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
module fault_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 55,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)(
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head = mem[rptr];
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            count <= count_next;
        end
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/mpu_fault_unit.sv
// mpu_fault_unit: captures MPU violation records into a FIFO, raises cpu_irq and exposes
// the records, overflow status and IRQ enable through a one-cycle register handshake.
module mpu_fault_unit import mpu_fault_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W = 22,
    parameter int DROP_W = 8
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              mpu_irq,
    input  logic [31:0]       pc_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wstrb,
    mpu_fault_unit_if.slave   bus,
    output logic              cpu_irq
);
    localparam int REC_W = rec_w(ADDR_W);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic irq_q, irq_en, ovf;
    logic [DROP_W-1:0] drop_cnt;
    logic req, wr, push, pop, clr, drop, full, empty;
    logic [CW-1:0] count, count_next;
    logic [REC_W-1:0] head;
    logic [31:0] head_pc, head_ad, status, rd;
    fault_fifo #(.DEPTH(FIFO_DEPTH), .W(REC_W)) u_fifo (
        .clk(clk),
        .resetn(resetn),
        .push(push),
        .pop(pop),
        .din({|cpu_wstrb, cpu_addr, pc_addr}),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count),
        .count_next(count_next)
    );
    always_comb begin
        req = bus.valid && !bus.ready;
        wr = req && |bus.wstrb;
        push = mpu_irq && !irq_q;
        pop = wr && bus.addr == REG_POP;
        clr = wr && bus.addr == REG_STATUS && bus.wdata[STS_OVF];
        // A pop while full frees the slot, so only an unpaired push overflows
        drop = push && full && !pop;
        head_pc = empty ? '0 : head[31:0];
        head_ad = empty ? '0 : 32'(head[32 +: ADDR_W]) | (32'(head[REC_W-1]) << HEAD_WR_BIT);
        status = 32'(count) | (32'(ovf) << STS_OVF) | (32'(drop_cnt) << STS_DROP_LSB);
        rd = bus.addr == REG_STATUS  ? status :
             bus.addr == REG_CTRL    ? 32'(irq_en) :
             bus.addr == REG_HEAD_PC ? head_pc :
             bus.addr == REG_HEAD_AD ? head_ad : '0;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            irq_q <= 1'b0;
            irq_en <= 1'b1;
            ovf <= 1'b0;
            drop_cnt <= '0;
            cpu_irq <= 1'b0;
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            irq_q <= mpu_irq;
            bus.ready <= req;
            bus.rdata <= req ? rd : '0;
            if (wr && bus.addr == REG_CTRL) irq_en <= bus.wdata[0];
            if (drop) begin
                ovf <= 1'b1;
                drop_cnt <= clr ? DROP_W'(1) : drop_cnt + DROP_W'(!(&drop_cnt));
            end else if (clr) begin
                ovf <= 1'b0;
                drop_cnt <= '0;
            end
            cpu_irq <= irq_en && count_next != '0;
        end
endmodule

// File: tb/tb_mpu_fault_unit.sv
// tb_mpu_fault_unit: directed and randomized checks of mpu_fault_unit against a queue-based model.
module tb_mpu_fault_unit;
    import mpu_fault_pkg::*;
    localparam int DEPTH = 4;
    localparam int AW = 22;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic mpu_irq = 1'b0;
    logic [31:0] pc_addr = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic [3:0] cpu_wstrb = '0;
    logic cpu_irq;
    mpu_fault_unit_if bus();
    mpu_fault_unit #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DROP_W(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .mpu_irq(mpu_irq),
        .pc_addr(pc_addr),
        .cpu_addr(cpu_addr),
        .cpu_wstrb(cpu_wstrb),
        .bus(bus),
        .cpu_irq(cpu_irq)
    );
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ad; } rec_t;
    rec_t q[$];
    logic m_ovf;
    int m_drop;
    logic m_en;
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_status();
        return 32'(q.size()) | (32'(m_ovf) << 8) | (32'(m_drop) << 16);
    endfunction

    function automatic logic [31:0] exp_irq();
        return 32'(m_en && q.size() != 0);
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovf = 1'b0;
        m_drop = 0;
        m_en = 1'b1;
    endfunction

    function automatic void m_push(input logic [31:0] pc, input logic [AW-1:0] ad, input logic [3:0] ws);
        rec_t r;
        r.pc = pc;
        r.ad = 32'(ad) | ((ws != 0) ? 32'h8000_0000 : 32'h0);
        if (q.size() < DEPTH) q.push_back(r);
        else begin
            m_ovf = 1'b1;
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
    endfunction

    task automatic reg_access(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] ws,
                              output logic [31:0] rd);
        int n;
        n = 0;
        bus.valid = 1'b1;
        bus.addr = a;
        bus.wdata = wd;
        bus.wstrb = ws;
        do begin
            step();
            n++;
        end while (!bus.ready && n < 8);
        check("ready_latency", 32'(n), 32'd1);
        rd = bus.rdata;
        bus.valid = 1'b0;
        bus.wstrb = '0;
        step();
        check("ready_one_cycle", 32'(bus.ready), 32'd0);
    endtask

    task automatic rd_check(input logic [2:0] a, input string tag);
        logic [31:0] rd, e;
        e = a == REG_STATUS  ? m_status() :
            a == REG_CTRL    ? 32'(m_en) :
            a == REG_HEAD_PC ? (q.size() != 0 ? q[0].pc : 32'h0) :
            a == REG_HEAD_AD ? (q.size() != 0 ? q[0].ad : 32'h0) : 32'h0;
        reg_access(a, 32'h0, 4'h0, rd);
        check(tag, rd, e);
    endtask

    task automatic pop_head();
        logic [31:0] rd;
        reg_access(REG_POP, $urandom, 4'hF, rd);
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic write_ctrl(input logic en);
        logic [31:0] rd;
        reg_access(REG_CTRL, {$urandom_range(0, 32'h7FFF_FFFF), en}, 4'h1 << $urandom_range(0, 3), rd);
        m_en = en;
    endtask

    task automatic clear_ovf();
        logic [31:0] rd;
        reg_access(REG_STATUS, 32'h100, 4'h3, rd);
        m_ovf = 1'b0;
        m_drop = 0;
    endtask

    task automatic fault(input logic [31:0] pc, input logic [AW-1:0] ad, input logic [3:0] ws, input int hold);
        mpu_irq = 1'b1;
        pc_addr = pc;
        cpu_addr = ad;
        cpu_wstrb = ws;
        step();
        m_push(pc, ad, ws);
        check("irq_after_edge", 32'(cpu_irq), exp_irq());
        // Capture must come from the edge cycle only; scramble the bus while the level is held
        for (int i = 1; i < hold; i++) begin
            pc_addr = $urandom;
            cpu_addr = AW'($urandom);
            cpu_wstrb = 4'($urandom);
            step();
        end
        mpu_irq = 1'b0;
        step();
    endtask

    task automatic rand_fault(input int hold);
        fault($urandom, AW'($urandom), ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bus.valid = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        m_reset();
        repeat (2) step();
        resetn = 1'b1;
        step();
        // Reset state
        check("reset_cpu_irq", 32'(cpu_irq), 32'd0);
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        rd_check(REG_STATUS, "reset_status");
        rd_check(REG_HEAD_PC, "reset_head_pc");
        rd_check(REG_HEAD_AD, "reset_head_ad");
        rd_check(REG_CTRL, "reset_ctrl");
        // Long held level gives one record
        fault(32'h100, AW'(32'h300), 4'hF, 10);
        rd_check(REG_STATUS, "held_status");
        check("held_count", m_status() & 32'hF, 32'd1);
        rd_check(REG_HEAD_PC, "held_head_pc");
        rd_check(REG_HEAD_AD, "held_head_ad");
        check("held_ad_value", q[0].ad, 32'h8000_0300);
        rd_check(REG_POP, "pop_read_zero");
        pop_head();
        check("irq_low_empty", 32'(cpu_irq), exp_irq());
        // Overflow: five edges into four slots
        for (int i = 0; i < 5; i++) fault(32'h1000 + 32'(i) * 4, AW'(32'h2000 + i), 4'(i), 1);
        rd_check(REG_STATUS, "ovf_status");
        check("ovf_expected_value", m_status(), 32'h0001_0104);
        for (int i = 0; i < 4; i++) pop_head();
        check("irq_after_pops", 32'(cpu_irq), 32'd0);
        pop_head();
        rd_check(REG_STATUS, "pop_empty_ignored");
        clear_ovf();
        rd_check(REG_STATUS, "ovf_cleared");
        // Full FIFO: pop and new fault on the same edge
        for (int i = 0; i < 4; i++) rand_fault(1);
        mpu_irq = 1'b1;
        pc_addr = 32'hCAFE_0000;
        cpu_addr = AW'(32'h3_ABCD);
        cpu_wstrb = 4'h0;
        bus.valid = 1'b1;
        bus.addr = REG_POP;
        bus.wdata = '0;
        bus.wstrb = 4'h8;
        step();
        check("simul_ready", 32'(bus.ready), 32'd1);
        void'(q.pop_front());
        m_push(32'hCAFE_0000, AW'(32'h3_ABCD), 4'h0);
        bus.valid = 1'b0;
        bus.wstrb = '0;
        mpu_irq = 1'b0;
        step();
        rd_check(REG_STATUS, "simul_status");
        for (int i = 0; i < 4; i++) begin
            rd_check(REG_HEAD_PC, "order_pc");
            rd_check(REG_HEAD_AD, "order_ad");
            pop_head();
        end
        // IRQ enable gating
        write_ctrl(1'b0);
        rand_fault(2);
        check("masked_irq", 32'(cpu_irq), 32'd0);
        rd_check(REG_STATUS, "masked_status");
        rd_check(REG_CTRL, "ctrl_zero");
        bus.valid = 1'b1;
        bus.addr = REG_CTRL;
        bus.wdata = 32'h1;
        bus.wstrb = 4'h1;
        step();
        m_en = 1'b1;
        bus.valid = 1'b0;
        bus.wstrb = '0;
        step();
        check("unmask_irq_next", 32'(cpu_irq), 32'd1);
        rd_check(REG_CTRL, "ctrl_one");
        pop_head();
        // Randomized mix against the model
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0, 1: rand_fault($urandom_range(1, 3));
                2: pop_head();
                3: rd_check(REG_STATUS, "rand_status");
                4: begin
                    rd_check(REG_HEAD_PC, "rand_head_pc");
                    rd_check(REG_HEAD_AD, "rand_head_ad");
                end
                5: write_ctrl($urandom_range(0, 3) != 0);
                default: begin
                    if ($urandom_range(0, 1) != 0) clear_ovf();
                    else rd_check(3'($urandom_range(5, 7)), "rand_unmapped");
                end
            endcase
            check("rand_cpu_irq", 32'(cpu_irq), exp_irq());
        end
        // Saturating drop counter
        write_ctrl(1'b1);
        for (int i = 0; i < 304; i++) rand_fault(1);
        rd_check(REG_STATUS, "drop_saturated");
        check("drop_is_255", (m_status() >> 16) & 32'hFF, 32'd255);
        // Reset in the middle of a read
        bus.valid = 1'b1;
        bus.addr = REG_STATUS;
        bus.wstrb = '0;
        #2 resetn = 1'b0;
        step();
        check("rst_no_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
        bus.valid = 1'b0;
        m_reset();
        resetn = 1'b1;
        step();
        check("post_rst_no_ready", 32'(bus.ready), 32'd0);
        rd_check(REG_STATUS, "post_rst_status");
        rd_check(REG_HEAD_PC, "post_rst_head_pc");
        rd_check(REG_CTRL, "post_rst_ctrl");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
